// File: rtl/dac_spi_seq.sv
// dac_spi_seq: SPI master for serial DACs (LTC2624-class). Sends one frame
// (single mode) or CHANNELS frames with incrementing address (sequence mode),
// optionally capturing the DAC's echoed frame for readback.
// Frame, MSB first: zero pad | command | address | data | PAD_LO zeros.
// Optional feature macro: DAC_SPI_READBACK_EN (rx capture of DAC_OUT).
// Ports:
//   CLK50MHZ, RST (async, active-low)
//   trig, seq, command, address, data : transfer request (sampled in IDLE)
//   busy, done, dac_datareceived       : status / readback
//   SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR  : DAC pins (outputs)
//   DAC_OUT                             : DAC serial echo (input)
module dac_spi_seq #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned CMD_W    = 4,
  parameter int unsigned PAD_LO   = 4,
  parameter int unsigned FRAME_W  = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SCK_DIV  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic                         CLK50MHZ,
  input  logic                         RST,
  input  logic                         trig,
  input  logic                         seq,
  input  logic [CMD_W-1:0]             command,
  input  logic [ADDR_W-1:0]            address,
  input  logic [CHANNELS*DATA_W-1:0]   data,
  output logic                         busy,
  output logic                         done,
  output logic [FRAME_W-1:0]           dac_datareceived,
  output logic                         SPI_SCK,
  output logic                         SPI_MOSI,
  output logic                         DAC_CS,
  output logic                         DAC_CLR,
  input  logic                         DAC_OUT
);

  localparam int unsigned CNT_MAX = (SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned IDX_W   = $clog2(CHANNELS + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP, DONE
  } state_t;

  state_t                       state, state_n;
  logic [CNT_W-1:0]             cnt, cnt_n;
  logic                         phase, phase_n;      // SCK level inside SHIFT
  logic [BIT_W-1:0]             bit_cnt, bit_n;
  logic [IDX_W-1:0]             sent, sent_n;        // frames completed
  logic [FRAME_W-1:0]           tx, tx_n;

  logic [CMD_W-1:0]             cmd_q;
  logic [ADDR_W-1:0]            addr_q;
  logic                         seq_q;
  logic [CHANNELS*DATA_W-1:0]   data_q;

  logic                         accept;
  logic                         half_end;
  logic                         frame_act;
  logic                         sck_d, mosi_d, cs_d, busy_d, done_d;

  // Assemble one frame; the unused top bits stay zero.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [CMD_W-1:0]  c,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d
  );
    return (FRAME_W'(c) << (ADDR_W + DATA_W + PAD_LO)) |
           (FRAME_W'(a) << (DATA_W + PAD_LO)) |
           (FRAME_W'(d) << PAD_LO);
  endfunction

  assign accept   = (state == IDLE) && trig;
  assign half_end = (cnt == CNT_W'(SCK_DIV - 1));

  // State register with sequencing counters and tx shifter.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      sent    <= '0;
      tx      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      phase   <= phase_n;
      bit_cnt <= bit_n;
      sent    <= sent_n;
      tx      <= tx_n;
    end
  end

  // Next-state and counter/shifter updates.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phase_n = phase;
    bit_n   = bit_cnt;
    sent_n  = sent;
    tx_n    = tx;
    case (state)
      IDLE: begin
        if (trig) begin
          state_n = SETUP;
          cnt_n   = '0;
          sent_n  = '0;
          tx_n    = build_frame(command, address, data[DATA_W-1:0]);
        end
      end
      SETUP: begin
        if (half_end) begin
          state_n = SHIFT;
          cnt_n   = '0;
          phase_n = 1'b0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (half_end) begin
          cnt_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
          end else begin
            // SCK falling edge: present the next bit
            phase_n = 1'b0;
            tx_n    = {tx[FRAME_W-2:0], 1'b0};
            if (bit_cnt == BIT_W'(FRAME_W - 1)) state_n = HOLD;
            else                                bit_n   = bit_cnt + BIT_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (half_end) begin
          state_n = GAP;
          cnt_n   = '0;
          sent_n  = sent + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(CS_GAP - 1)) begin
          cnt_n = '0;
          if (seq_q && (sent < IDX_W'(CHANNELS))) begin
            state_n = SETUP;
            tx_n    = build_frame(cmd_q, addr_q + ADDR_W'(sent),
                                  data_q[sent*DATA_W +: DATA_W]);
          end else begin
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the pins come straight off flops.
  always_comb begin
    frame_act = (state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD);
    sck_d     = (state_n == SHIFT) && phase_n;
    mosi_d    = frame_act ? tx_n[FRAME_W-1] : 1'b0;
    cs_d      = !frame_act;
    busy_d    = frame_act || (state_n == GAP);
    done_d    = (state_n == DONE);
  end

  // Request capture at acceptance.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      cmd_q  <= '0;
      addr_q <= '0;
      seq_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      cmd_q  <= command;
      addr_q <= address;
      seq_q  <= seq;
      data_q <= data;
    end
  end

  // Registered pins and status.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      SPI_SCK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      DAC_CS   <= 1'b1;
      DAC_CLR  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      SPI_SCK  <= sck_d;
      SPI_MOSI <= mosi_d;
      DAC_CS   <= cs_d;
      DAC_CLR  <= 1'b1;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef DAC_SPI_READBACK_EN
  logic [FRAME_W-1:0] rx;

  // Sample DAC_OUT on each SCK rising edge; publish the frame at DONE.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      rx               <= '0;
      dac_datareceived <= '0;
    end else begin
      if ((state == SHIFT) && half_end && !phase) rx <= {rx[FRAME_W-2:0], DAC_OUT};
      if (state_n == DONE) dac_datareceived <= rx;
    end
  end
`else
  logic unused_dac_out;
  assign unused_dac_out   = DAC_OUT;
  assign dac_datareceived = '0;
`endif

endmodule

// File: tb/tb_dac_spi_seq.sv
// Testbench for dac_spi_seq: randomized and directed transfers, DAC echo
// model, scoreboard of expected frames and readback values.
module tb_dac_spi_seq;

  localparam int unsigned DATA_W   = 12;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned CMD_W    = 4;
  localparam int unsigned PAD_LO   = 4;
  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SCK_DIV  = 2;
  localparam int unsigned CS_GAP   = 4;
  localparam int unsigned DW       = CHANNELS * DATA_W;
  localparam int unsigned FRAME_CYC = (2 + 2 * FRAME_W) * SCK_DIV;
`ifdef DAC_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               RST = 1'b0;
  logic               trig = 1'b0;
  logic               seq = 1'b0;
  logic [CMD_W-1:0]   command = '0;
  logic [ADDR_W-1:0]  address = '0;
  logic [DW-1:0]      data = '0;
  logic               busy, done;
  logic [FRAME_W-1:0] dac_datareceived;
  logic               SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR;
  logic               DAC_OUT = 1'b0;

  int tests = 0;
  int fails = 0;

  dac_spi_seq #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .PAD_LO(PAD_LO),
    .FRAME_W(FRAME_W), .CHANNELS(CHANNELS), .SCK_DIV(SCK_DIV), .CS_GAP(CS_GAP)
  ) dut (
    .CLK50MHZ(clk), .RST(RST), .trig(trig), .seq(seq), .command(command),
    .address(address), .data(data), .busy(busy), .done(done),
    .dac_datareceived(dac_datareceived), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .DAC_CS(DAC_CS), .DAC_CLR(DAC_CLR), .DAC_OUT(DAC_OUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [FRAME_W-1:0] exp_frame_q[$];
  logic [FRAME_W-1:0] exp_done_q[$];
  logic [FRAME_W-1:0] seen_q[$];
  logic [FRAME_W-1:0] last_word = '0;   // last complete frame the DAC received

  function automatic logic [FRAME_W-1:0] frame_word(input longint c, input longint a, input longint d);
    longint v;
    v = c * (longint'(1) << (ADDR_W + DATA_W + PAD_LO)) +
        a * (longint'(1) << (DATA_W + PAD_LO)) +
        d * (longint'(1) << PAD_LO);
    return FRAME_W'(v);
  endfunction

  // Issue one request and push the expected frames / readback.
  task automatic issue(input logic s, input logic [CMD_W-1:0] c, input logic [ADDR_W-1:0] a,
                       input logic [DW-1:0] d);
    int n;
    logic [FRAME_W-1:0] w, rx;
    @(negedge clk);
    seq = s; command = c; address = a; data = d; trig = 1'b1;
    n = s ? CHANNELS : 1;
    rx = last_word;
    for (int i = 0; i < n; i++) begin
      w = frame_word(longint'(c), (longint'(a) + i) % (longint'(1) << ADDR_W),
                     longint'(d[i*DATA_W +: DATA_W]));
      exp_frame_q.push_back(w);
      rx = last_word;
      last_word = w;
    end
    exp_done_q.push_back(RB ? rx : '0);
    @(negedge clk);
    trig = 1'b0;
    seq = 1'($urandom); command = CMD_W'($urandom); address = ADDR_W'($urandom);
    data = DW'({$urandom(), $urandom()});
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 64'(seen), 64'(1));
    @(negedge clk);
    check({name, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  // DAC model: echoes the previous complete frame on DAC_OUT.
  logic [FRAME_W-1:0] cap = '0, echo = '0, out_sr = '0;
  int                 ncap = 0;
  logic               m_cs = 1'b1, m_sck = 1'b0;
  initial begin
    forever begin
      @(SPI_SCK or DAC_CS);
      if (m_cs && !DAC_CS) begin
        out_sr = echo; ncap = 0; cap = '0;
        DAC_OUT = out_sr[FRAME_W-1];
      end else if (!m_cs && DAC_CS) begin
        if (ncap == FRAME_W) echo = cap;
      end
      if (!DAC_CS) begin
        if (!m_sck && SPI_SCK) begin
          cap = {cap[FRAME_W-2:0], SPI_MOSI};
          ncap++;
        end
        if (m_sck && !SPI_SCK) begin
          out_sr = {out_sr[FRAME_W-2:0], 1'b0};
          DAC_OUT = out_sr[FRAME_W-1];
        end
      end
      m_cs = DAC_CS; m_sck = SPI_SCK;
    end
  end

  // Monitor: reassemble frames from the pins and score them.
  logic               cs_prev = 1'b1, sck_prev = 1'b0, in_xfer = 1'b0;
  int                 low_cnt = 0, high_cnt = 0, rises = 0;
  logic [FRAME_W-1:0] word = '0, e;
  initial begin
    forever begin
      @(negedge clk);
      if (!RST) begin
        cs_prev = 1'b1; sck_prev = 1'b0; in_xfer = 1'b0;
        low_cnt = 0; high_cnt = 0; rises = 0; word = '0;
      end else begin
        if (cs_prev && !DAC_CS) begin
          if (in_xfer) check("cs_gap_min", 64'(high_cnt >= CS_GAP), 64'(1));
          in_xfer = 1'b1; low_cnt = 0; rises = 0; word = '0;
        end
        if (!cs_prev && DAC_CS) begin
          check("frame_expected", 64'(exp_frame_q.size() != 0), 64'(1));
          if (exp_frame_q.size() != 0) begin
            e = exp_frame_q.pop_front();
            check("frame_mosi", 64'(word), 64'(e));
            check("sck_rises", 64'(rises), 64'(FRAME_W));
            check("cs_low_cycles", 64'(low_cnt), 64'(FRAME_CYC));
          end
          seen_q.push_back(word);
          high_cnt = 0;
        end
        if (!DAC_CS) begin
          low_cnt++;
          if (SPI_SCK && !sck_prev) begin
            word = {word[FRAME_W-2:0], SPI_MOSI};
            rises++;
          end
        end else begin
          high_cnt++;
        end
        if (done) begin
          check("done_expected", 64'(exp_done_q.size() != 0), 64'(1));
          if (exp_done_q.size() != 0) begin
            e = exp_done_q.pop_front();
            check("readback", 64'(dac_datareceived), 64'(e));
            check("busy_at_done", 64'(busy), 64'(0));
            check("frames_drained", 64'(exp_frame_q.size()), 64'(0));
          end
          in_xfer = 1'b0;
        end
        cs_prev = DAC_CS; sck_prev = SPI_SCK;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] saved;
    logic               sp;
    int                 nr;
    bit                 hit;

    // Reset values, then reset again mid-idle
    repeat (3) @(negedge clk);
    #2 RST = 1'b1;
    repeat (5) @(negedge clk);
    #3 RST = 1'b0;
    #1;
    check("rst_cs", 64'(DAC_CS), 64'(1));
    check("rst_sck", 64'(SPI_SCK), 64'(0));
    check("rst_mosi", 64'(SPI_MOSI), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_clr", 64'(DAC_CLR), 64'(0));
    check("rst_rdata", 64'(dac_datareceived), 64'(0));
    @(negedge clk);
    #2 RST = 1'b1;
    #1 check("clr_before_edge", 64'(DAC_CLR), 64'(0));
    @(posedge clk);
    #1 check("clr_after_edge", 64'(DAC_CLR), 64'(1));

    // Single write
    seen_q.delete();
    issue(1'b0, 4'd3, 4'd2, DW'(12'hABC));
    wait_done("single1");
    check("single1_count", 64'(seen_q.size()), 64'(1));
    if (seen_q.size() != 0) check("single1_word", 64'(seen_q[0]), 64'(32'h0032ABC0));

    // Second single: readback returns the first frame
    issue(1'b0, 4'd3, 4'd1, DW'(0));
    wait_done("single2");
    check("readback_prev", 64'(dac_datareceived), RB ? 64'(32'h0032ABC0) : 64'(0));

    // Sequence, address 0
    seen_q.delete();
    issue(1'b1, 4'd3, 4'd0, {12'h444, 12'h333, 12'h222, 12'h111});
    wait_done("seq0");
    check("seq0_count", 64'(seen_q.size()), 64'(CHANNELS));
    for (int i = 0; i < seen_q.size(); i++) begin
      check("seq0_addr", 64'(seen_q[i][19:16]), 64'(i));
      check("seq0_data", 64'(seen_q[i][15:4]), 64'(12'h111 * (i + 1)));
    end

    // Address wrap
    seen_q.delete();
    issue(1'b1, 4'd3, 4'd14, DW'({$urandom(), $urandom()}));
    wait_done("wrap");
    for (int i = 0; i < seen_q.size(); i++)
      check("wrap_addr", 64'(seen_q[i][19:16]), 64'((14 + i) % 16));

    // Trig pulsed mid-frame is ignored
    seen_q.delete();
    issue(1'b0, 4'd2, 4'd5, DW'({$urandom(), $urandom()}));
    repeat (40) @(negedge clk);
    trig = 1'b1; seq = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_done("midtrig");
    repeat (300) @(negedge clk);
    check("midtrig_frames", 64'(seen_q.size()), 64'(1));

    // Reset at bit 10 aborts with no done
    saved = last_word;
    issue(1'b0, 4'd3, 4'd7, DW'(12'h5A5));
    sp = SPI_SCK; nr = 0;
    for (int c = 0; c < 1000 && nr < 10; c++) begin
      @(negedge clk);
      if (SPI_SCK && !sp) nr++;
      sp = SPI_SCK;
    end
    check("abort_reached_bit10", 64'(nr), 64'(10));
    #2 RST = 1'b0;
    #1 check("abort_cs", 64'(DAC_CS), 64'(1));
    check("abort_sck", 64'(SPI_SCK), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    exp_frame_q.delete(); exp_done_q.delete();
    last_word = saved;
    hit = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) hit = 1'b1;
    end
    check("abort_no_done", 64'(hit), 64'(0));
    #2 RST = 1'b1;
    repeat (2) @(negedge clk);
    seen_q.delete();
    issue(1'b0, 4'd3, 4'd7, DW'(12'h5A5));
    wait_done("after_abort");
    check("after_abort_count", 64'(seen_q.size()), 64'(1));

    // Randomized transfers
    for (int t = 0; t < 16; t++) begin
      issue(1'($urandom), CMD_W'($urandom), ADDR_W'($urandom), DW'({$urandom(), $urandom()}));
      wait_done("rand");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    check("final_frames_q", 64'(exp_frame_q.size()), 64'(0));
    check("final_done_q", 64'(exp_done_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
